axi_ad9371_rx_pack: RTL and testbench

AXI_AD9371_RX_PACK -- requirements
Module: axi_ad9371_rx_pack

---
 rtl/axi_ad9371_rx_pack_pkg.sv | 46 ++++
 rtl/axi_ad9371_rx_pack_compress.sv | 24 ++
 rtl/axi_ad9371_rx_pack.sv | 123 ++++++++++++
 tb/tb_axi_ad9371_rx_pack.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ad9371_rx_pack_pkg.sv
// Shared types and helpers for the AD9371 receive-path sample packer:
// FSM states, lane width and the legal enabled-lane counts.
package axi_ad9371_rx_pack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_RESYNC = 2'd2
  } state_t;

  localparam int LANE_WIDTH = 16;
  localparam int NUM_LANES  = 4;

  // Only these enabled-lane counts divide a 64-bit word evenly
  typedef enum logic [2:0] {
    N_ONE  = 3'd1,
    N_TWO  = 3'd2,
    N_FOUR = 3'd4
  } lane_n_t;

  function automatic logic [2:0] lane_count(input logic [3:0] en);
    lane_count = 3'(en[0]) + 3'(en[1]) + 3'(en[2]) + 3'(en[3]);
  endfunction

  function automatic logic n_legal(input logic [2:0] n);
    n_legal = (n == N_ONE) || (n == N_TWO) || (n == N_FOUR);
  endfunction

  // Index of the set that completes a word
  function automatic logic [1:0] last_fill(input logic [2:0] n);
    case (n)
      N_ONE:   last_fill = 2'd3;
      N_TWO:   last_fill = 2'd1;
      default: last_fill = 2'd0;
    endcase
  endfunction

  function automatic logic [6:0] fill_offset(input logic [1:0] fill, input logic [2:0] n);
    case (n)
      N_ONE:   fill_offset = {1'b0, fill, 4'b0000};
      N_TWO:   fill_offset = {1'b0, fill[0], 5'b00000};
      default: fill_offset = 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/axi_ad9371_rx_pack_compress.sv
// Squeezes the enabled channel samples of one sample set, in ascending
// channel order, into the low bits of the output.
module axi_ad9371_rx_pack_compress
  import axi_ad9371_rx_pack_pkg::*;
(
  input  logic [NUM_LANES-1:0]            enable,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] data,
  output logic [NUM_LANES*LANE_WIDTH-1:0] compressed
);

  logic [1:0] slot;

  always_comb begin
    compressed = '0;
    slot       = 2'd0;
    for (int c = 0; c < NUM_LANES; c++) begin
      if (enable[c]) begin
        compressed[slot*LANE_WIDTH +: LANE_WIDTH] = data[c*LANE_WIDTH +: LANE_WIDTH];
        slot = slot + 2'd1;
      end
    end
  end

endmodule

// File: rtl/axi_ad9371_rx_pack.sv
// Packs 1, 2 or 4 enabled 16-bit ADC lanes into 64-bit words for the DMA.
// Defining AD9371_RX_PACK_STATUS_EN adds word and dropped-partial counters.
module axi_ad9371_rx_pack
  import axi_ad9371_rx_pack_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int PACK_WIDTH   = 64
) (
  input  logic                               adc_clk,
  input  logic                               adc_rstn,
  input  logic [NUM_CHANNELS-1:0]            adc_enable,
  input  logic                               adc_valid,
  input  logic [NUM_CHANNELS*LANE_WIDTH-1:0] adc_data,
  output logic                               pack_valid,
  output logic [PACK_WIDTH-1:0]              pack_data,
  output logic                               pack_sync,
  input  logic                               pack_ovf,
  output logic                               adc_dovf,
  output logic                               pack_cfg_err
`ifdef AD9371_RX_PACK_STATUS_EN
  ,
  output logic [31:0]                        pack_word_count,
  output logic [15:0]                        pack_drop_count
`endif
);

  state_t                  state_reg;
  logic [NUM_CHANNELS-1:0] enable_reg;
  logic [1:0]              fill_reg;
  logic [PACK_WIDTH-1:0]   acc_reg;
  logic                    sync_pending_reg;

  logic [PACK_WIDTH-1:0]   compressed;
  logic [PACK_WIDTH-1:0]   merged;
  logic [2:0]              lane_n;
  logic                    new_legal;
  logic                    enable_change;
  logic                    word_evt;

  // Compression follows the latched pattern; a set arriving with a new
  // pattern is dropped anyway.
  axi_ad9371_rx_pack_compress u_compress (
    .enable     (enable_reg),
    .data       (adc_data),
    .compressed (compressed)
  );

  assign lane_n        = lane_count(enable_reg);
  assign new_legal     = n_legal(lane_count(adc_enable));
  assign enable_change = (adc_enable != enable_reg);
  assign merged        = ((fill_reg == 2'd0) ? '0 : acc_reg)
                       | (compressed << fill_offset(fill_reg, lane_n));
  assign word_evt      = (state_reg == ST_FILL) && !enable_change && adc_valid
                       && (fill_reg == last_fill(lane_n));

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      state_reg        <= ST_IDLE;
      enable_reg       <= '0;
      fill_reg         <= 2'd0;
      acc_reg          <= '0;
      sync_pending_reg <= 1'b0;
      pack_valid       <= 1'b0;
      pack_data        <= '0;
      pack_sync        <= 1'b0;
      adc_dovf         <= 1'b0;
      pack_cfg_err     <= 1'b0;
    end else begin
      pack_valid   <= 1'b0;
      pack_sync    <= 1'b0;
      adc_dovf     <= pack_ovf;
      pack_cfg_err <= !new_legal;
      case (state_reg)
        ST_IDLE, ST_RESYNC: begin
          fill_reg <= 2'd0;
          if (new_legal) begin
            state_reg        <= ST_FILL;
            enable_reg       <= adc_enable;
            sync_pending_reg <= 1'b1;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_FILL: begin
          if (enable_change) begin
            state_reg <= ST_RESYNC;
            fill_reg  <= 2'd0;
          end else if (adc_valid) begin
            if (word_evt) begin
              pack_valid       <= 1'b1;
              pack_data        <= merged;
              pack_sync        <= sync_pending_reg;
              sync_pending_reg <= 1'b0;
              fill_reg         <= 2'd0;
            end else begin
              acc_reg  <= merged;
              fill_reg <= fill_reg + 2'd1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef AD9371_RX_PACK_STATUS_EN
  logic drop_evt;
  assign drop_evt = (state_reg == ST_FILL) && enable_change && (fill_reg != 2'd0);

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      pack_word_count <= '0;
      pack_drop_count <= '0;
    end else begin
      if (word_evt)
        pack_word_count <= pack_word_count + 32'd1;
      if (drop_evt && (pack_drop_count != 16'hFFFF))
        pack_drop_count <= pack_drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_ad9371_rx_pack.sv
// Scoreboard bench for axi_ad9371_rx_pack: a lane-queue model predicts
// each packed word, its sync flag and the cycle it must appear on.
module tb_axi_ad9371_rx_pack;

  logic        adc_clk = 1'b0;
  logic        adc_rstn = 1'b0;
  logic [3:0]  adc_enable = 4'b1111;
  logic        adc_valid = 1'b0;
  logic [63:0] adc_data = '0;
  logic        pack_valid;
  logic [63:0] pack_data;
  logic        pack_sync;
  logic        pack_ovf = 1'b0;
  logic        adc_dovf;
  logic        pack_cfg_err;
`ifdef AD9371_RX_PACK_STATUS_EN
  logic [31:0] pack_word_count;
  logic [15:0] pack_drop_count;
`endif

  axi_ad9371_rx_pack dut (
    .adc_clk      (adc_clk),
    .adc_rstn     (adc_rstn),
    .adc_enable   (adc_enable),
    .adc_valid    (adc_valid),
    .adc_data     (adc_data),
    .pack_valid   (pack_valid),
    .pack_data    (pack_data),
    .pack_sync    (pack_sync),
    .pack_ovf     (pack_ovf),
    .adc_dovf     (adc_dovf),
    .pack_cfg_err (pack_cfg_err)
`ifdef AD9371_RX_PACK_STATUS_EN
    ,
    .pack_word_count (pack_word_count),
    .pack_drop_count (pack_drop_count)
`endif
  );

  always #5 adc_clk = ~adc_clk;

  typedef struct {
    logic [63:0] data;
    logic        sync;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_lanes[$];
  logic        m_sync = 1'b1;
  logic        m_legal = 1'b1;
  int          cyc = 0;
  int          words = 0;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_word = '0;

  always @(posedge adc_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Output monitor: every word must match the head of the scoreboard
  always @(negedge adc_clk) begin
    if (adc_rstn) begin
      if (pack_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(pack_valid), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word_data", pack_data, e.data);
          check("word_sync", 64'(pack_sync), 64'(e.sync));
          check("word_latency", 64'(cyc), 64'(e.due));
        end
        last_word = pack_data;
        words++;
      end else if (pack_sync) begin
        check("sync_without_valid", 64'(pack_sync), 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      adc_valid = 1'b0;
    end
  endtask

  task automatic set_enable(input logic [3:0] e);
    step();
    adc_valid = 1'b0;
    if (e != adc_enable) begin
      m_lanes.delete();
      m_sync = 1'b1;
    end
    adc_enable = e;
    m_legal = ($countones(e) == 1) || ($countones(e) == 2) || ($countones(e) == 4);
  endtask

  task automatic send_set(input logic [63:0] d);
    exp_t e;
    step();
    adc_valid = 1'b1;
    adc_data  = d;
    if (m_legal) begin
      for (int c = 0; c < 4; c++)
        if (adc_enable[c]) m_lanes.push_back(d[c*16 +: 16]);
      if (m_lanes.size() == 4) begin
        e.data = {m_lanes[3], m_lanes[2], m_lanes[1], m_lanes[0]};
        e.sync = m_sync;
        e.due  = cyc + 1;
        exp_q.push_back(e);
        m_sync = 1'b0;
        m_lanes.delete();
      end
    end
  endtask

  initial begin
    int w0;
    int w_rst;

    // Reset state
    repeat (2) @(posedge adc_clk);
    #1;
    check("rst_valid", 64'(pack_valid), 64'd0);
    check("rst_data", pack_data, 64'd0);
    check("rst_sync", 64'(pack_sync), 64'd0);
    check("rst_dovf", 64'(adc_dovf), 64'd0);
    check("rst_cfg_err", 64'(pack_cfg_err), 64'd0);
    adc_rstn = 1'b1;
    idle(2);
    check("cfg_err_legal", 64'(pack_cfg_err), 64'd0);

    // Four lanes: one word per set, back to back
    send_set(64'h0123_4567_89AB_CDEF);
    send_set(64'hFEDC_BA98_7654_3210);
    send_set(64'h5A5A_A5A5_1234_8765);
    idle(2);
    check("s037_drained", 64'(exp_q.size()), 64'd0);

    // Overflow passes through one register
    step();
    pack_ovf = 1'b1;
    #1;
    check("dovf_not_yet", 64'(adc_dovf), 64'd0);
    step();
    check("dovf_delayed", 64'(adc_dovf), 64'd1);
    pack_ovf = 1'b0;
    step();
    check("dovf_clear", 64'(adc_dovf), 64'd0);

    // Two lanes i0/i1
    set_enable(4'b0101);
    idle(1);
    send_set({16'hDEAD, 16'h2222, 16'hBEEF, 16'h1111});
    send_set({16'hCAFE, 16'h4444, 16'hF00D, 16'h3333});
    idle(2);
    check("s038_word", last_word, 64'h4444_3333_2222_1111);

    // One lane, with valid gaps
    set_enable(4'b0001);
    idle(1);
    send_set({16'hDEAD, 16'hBEEF, 16'hCAFE, 16'h00A0});
    idle(1);
    send_set({16'h1111, 16'h2222, 16'h3333, 16'h00A1});
    idle(3);
    send_set({16'h4444, 16'h5555, 16'h6666, 16'h00A2});
    send_set({16'h7777, 16'h8888, 16'h9999, 16'h00A3});
    idle(2);
    check("s039_word", last_word, 64'h00A3_00A2_00A1_00A0);

    // Pattern change mid-word: partial dropped, one-cycle resync
    w0 = words;
    send_set(64'h0000_0000_0000_0B01);
    send_set(64'h0000_0000_0000_0B02);
    set_enable(4'b0011);
    idle(1);
    check("s040_no_word", 64'(words - w0), 64'd0);
`ifdef AD9371_RX_PACK_STATUS_EN
    check("s040_drop_count", 64'(pack_drop_count), 64'd1);
`endif
    send_set(64'h0000_0000_C002_C001);
    send_set(64'h0000_0000_C004_C003);
    idle(2);
    check("s040_word", last_word, 64'hC004_C003_C002_C001);

    // Illegal pattern: error flag, nothing emitted
    set_enable(4'b0111);
    idle(1);
    check("s041_cfg_err", 64'(pack_cfg_err), 64'd1);
    w0 = words;
    for (int k = 0; k < 20; k++) send_set({4{16'(k + 16'h300)}});
    idle(2);
    check("s041_no_words", 64'(words - w0), 64'd0);
    check("s041_cfg_err_hold", 64'(pack_cfg_err), 64'd1);
    set_enable(4'b1111);
    idle(1);
    check("s041_cfg_err_clear", 64'(pack_cfg_err), 64'd0);
    send_set(64'h1357_9BDF_2468_ACE0);
    idle(2);
    check("s041_resume", 64'(words - w0), 64'd1);

    // Reset mid-word
    set_enable(4'b0001);
    idle(1);
    send_set(64'h0000_0000_0000_0D01);
    send_set(64'h0000_0000_0000_0D02);
    send_set(64'h0000_0000_0000_0D03);
    pack_ovf = 1'b1;
    idle(1);
    #2;
    adc_rstn = 1'b0;
    #1;
    check("s042_rst_data", pack_data, 64'd0);
    check("s042_rst_valid", 64'(pack_valid), 64'd0);
    check("s042_rst_dovf", 64'(adc_dovf), 64'd0);
    check("s042_rst_cfg_err", 64'(pack_cfg_err), 64'd0);
    m_lanes.delete();
    m_sync = 1'b1;
    pack_ovf = 1'b0;
    step();
    step();
    adc_rstn = 1'b1;
    idle(2);
    w_rst = words;
    send_set(64'h0000_0000_0000_0E00);
    send_set(64'h0000_0000_0000_0E01);
    send_set(64'h0000_0000_0000_0E02);
    idle(2);
    check("s042_no_early_word", 64'(words - w_rst), 64'd0);
    send_set(64'h0000_0000_0000_0E03);
    idle(3);
    check("s042_one_word", 64'(words - w_rst), 64'd1);
    check("s042_word", last_word, 64'h0E03_0E02_0E01_0E00);
`ifdef AD9371_RX_PACK_STATUS_EN
    check("word_count", 64'(pack_word_count), 64'(words - w_rst));
    check("drop_count_rst", 64'(pack_drop_count), 64'd0);
`endif
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
